// File: rtl/radix4_demux_framer.sv
// Serial-to-frame demultiplexer: items fill lanes 0..3 of an assembly buffer and
// completed or flushed frames move into a ready/valid output register.
module radix4_demux_framer #(
  parameter int WIDTH = 1,
  parameter int CNTW  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*WIDTH-1:0]   out_word,
  output logic [3:0]           out_mask,
  output logic [1:0]           out_sel,
  output logic [CNTW-1:0]      frame_cnt
);

  logic [1:0]         r_cnt;
  logic [4*WIDTH-1:0] r_acc;
  logic [3:0]         r_mask;
  logic               r_out_valid;
  logic [4*WIDTH-1:0] r_out_word;
  logic [3:0]         r_out_mask;
  logic [1:0]         r_out_sel;
  logic [CNTW-1:0]    r_frame_cnt;

  logic               w_free;
  logic               w_accept;
  logic               w_take;
  logic               w_full;
  logic               w_flush_xfer;
  logic               w_xfer;
  logic [4*WIDTH-1:0] w_acc_next;
  logic [3:0]         w_mask_next;

  function automatic logic [1:0] f_top_lane(input logic [3:0] mask);
    if (mask[3]) begin
      return 2'd3;
    end else if (mask[2]) begin
      return 2'd2;
    end else if (mask[1]) begin
      return 2'd1;
    end else begin
      return 2'd0;
    end
  endfunction

  // A completing item is only refused when the held frame cannot leave this cycle.
  assign in_ready     = !((r_cnt == 2'd3) && r_out_valid && !out_ready);
  assign w_free       = !r_out_valid || out_ready;
  assign w_accept     = in_valid && in_ready;
  assign w_take       = r_out_valid && out_ready;
  assign w_full       = w_accept && (r_cnt == 2'd3);
  assign w_flush_xfer = flush && w_free && ((r_mask != 4'b0000) || w_accept);
  assign w_xfer       = w_full || w_flush_xfer;

  // Assembly buffer as it would look after this cycle's accept.
  always_comb begin
    w_acc_next  = r_acc;
    w_mask_next = r_mask;
    for (int k = 0; k < 4; k++) begin
      w_acc_next[k*WIDTH +: WIDTH] = (w_accept && (r_cnt == 2'(k))) ? in_data
                                                                      : r_acc[k*WIDTH +: WIDTH];
      w_mask_next[k] = r_mask[k] | (w_accept && (r_cnt == 2'(k)));
    end
  end

  // Assembly state, output frame register and frame counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= 2'd0;
      r_acc       <= '0;
      r_mask      <= 4'b0000;
      r_out_valid <= 1'b0;
      r_out_word  <= '0;
      r_out_mask  <= 4'b0000;
      r_out_sel   <= 2'd0;
      r_frame_cnt <= '0;
    end else begin
      if (w_xfer) begin
        r_cnt  <= 2'd0;
        r_acc  <= '0;
        r_mask <= 4'b0000;
      end else if (w_accept) begin
        r_cnt  <= r_cnt + 2'd1;
        r_acc  <= w_acc_next;
        r_mask <= w_mask_next;
      end

      if (w_xfer) begin
        r_out_valid <= 1'b1;
        r_out_word  <= w_acc_next;
        r_out_mask  <= w_mask_next;
        r_out_sel   <= f_top_lane(w_mask_next);
      end else if (w_take) begin
        r_out_valid <= 1'b0;
      end

      if (w_take) begin
        r_frame_cnt <= r_frame_cnt + CNTW'(1);
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_word  = r_out_word;
  assign out_mask  = r_out_mask;
  assign out_sel   = r_out_sel;
  assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_radix4_demux_framer.sv
// Directed bench for radix4_demux_framer (WIDTH=1, CNTW=2): expected frames are
// queued as stimulus is issued and compared whenever the DUT hands a frame off.
module tb_radix4_demux_framer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [0:0] in_data;
  logic       flush;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_word;
  logic [3:0] out_mask;
  logic [1:0] out_sel;
  logic [1:0] frame_cnt;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int t0;

  // Expected frame: {word[3:0], mask[3:0], sel[1:0]}
  logic [9:0] exp_q[$];
  logic [9:0] exp_f;

  radix4_demux_framer #(.WIDTH(1), .CNTW(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
    .out_mask(out_mask), .out_sel(out_sel), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every take must match the oldest queued frame; a held frame must match it too.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_frame", 32'(out_valid), 32'(0));
      end else if (out_ready) begin
        exp_f = exp_q.pop_front();
        check("take_word", 32'(out_word), 32'(exp_f[9:6]));
        check("take_mask", 32'(out_mask), 32'(exp_f[5:2]));
        check("take_sel",  32'(out_sel),  32'(exp_f[1:0]));
      end else begin
        check("held_word", 32'(out_word), 32'(exp_q[0][9:6]));
        check("held_mask", 32'(out_mask), 32'(exp_q[0][5:2]));
        check("held_sel",  32'(out_sel),  32'(exp_q[0][1:0]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic d);
    logic ok;
    int   n;
    in_valid = 1'b1;
    in_data  = d;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    check("send_accept", 32'(ok), 32'(1));
  endtask

  task automatic send_word(input logic [3:0] w);
    for (int k = 0; k < 4; k++) send(w[k]);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 32'(0));
    check({tag, "_out_word"},  32'(out_word),  32'(0));
    check({tag, "_out_mask"},  32'(out_mask),  32'(0));
    check({tag, "_out_sel"},   32'(out_sel),   32'(0));
    check({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(0));
    check({tag, "_in_ready"},  32'(in_ready),  32'(1));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 1'b0; flush = 1'b0; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check_reset_state("reset");

    // Full frame 1,1,0,0
    exp_q.push_back({4'b0011, 4'b1111, 2'd3});
    send_word(4'b0011);
    check("full_out_valid", 32'(out_valid), 32'(1));
    tick();
    check("full_frame_cnt", 32'(frame_cnt), 32'(1));
    check("full_cleared", 32'(out_valid), 32'(0));

    // Partial frame 1,0,1 then flush with no item
    exp_q.push_back({4'b0101, 4'b0111, 2'd2});
    send(1'b1); send(1'b0); send(1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_out_valid", 32'(out_valid), 32'(1));
    tick();
    check("flush_frame_cnt", 32'(frame_cnt), 32'(2));

    // Backpressure: held frame, three more accepted, fourth stalls
    out_ready = 1'b0;
    exp_q.push_back({4'b1001, 4'b1111, 2'd3});
    send_word(4'b1001);
    send(1'b0); send(1'b1); send(1'b1);
    exp_q.push_back({4'b1110, 4'b1111, 2'd3});
    in_valid = 1'b1; in_data = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_in_ready", 32'(in_ready), 32'(0));
      check("stall_out_valid", 32'(out_valid), 32'(1));
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("release_in_ready", 32'(in_ready), 32'(1));
    tick();
    in_valid = 1'b0;
    check("nobubble_out_valid", 32'(out_valid), 32'(1));
    tick();
    check("bp_cleared", 32'(out_valid), 32'(0));
    check("bp_frame_cnt_wrap", 32'(frame_cnt), 32'(0));

    // Continuous stream of 8 items
    exp_q.push_back({4'b1101, 4'b1111, 2'd3});
    exp_q.push_back({4'b0010, 4'b1111, 2'd3});
    t0 = cyc;
    send_word(4'b1101);
    send_word(4'b0010);
    check("stream_cycles", 32'(cyc - t0), 32'(8));
    tick();
    check("stream_frame_cnt", 32'(frame_cnt), 32'(2));

    // Reset with a pending frame and a partial one
    out_ready = 1'b0;
    exp_q.push_back({4'b0001, 4'b1111, 2'd3});
    send_word(4'b0001);
    send(1'b1); send(1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    check_reset_state("midrst");
    out_ready = 1'b1;
    exp_q.push_back({4'b0110, 4'b1111, 2'd3});
    send_word(4'b0110);
    tick();
    check("postrst_frame_cnt", 32'(frame_cnt), 32'(1));

    // Counter wrap with CNTW=2
    for (int f = 0; f < 3; f++) begin
      exp_f = {4'(f + 5), 4'b1111, 2'd3};
      exp_q.push_back(exp_f);
      send_word(4'(f + 5));
      tick();
      check("wrap_frame_cnt", 32'(frame_cnt), 32'((2 + f) % 4));
    end

    // Flush on an empty frame does nothing
    flush = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("empty_flush_out_valid", 32'(out_valid), 32'(0));
      tick();
    end
    flush = 1'b0;

    // Flush together with an accepted item includes that item
    exp_q.push_back({4'b0011, 4'b0011, 2'd1});
    send(1'b1);
    flush = 1'b1;
    send(1'b1);
    flush = 1'b0;
    tick();
    check("flush_accept_frame_cnt", 32'(frame_cnt), 32'(1));

    // Flush coinciding with the lane-3 accept yields one full frame
    exp_q.push_back({4'b1010, 4'b1111, 2'd3});
    send(1'b0); send(1'b1); send(1'b0);
    flush = 1'b1;
    send(1'b1);
    flush = 1'b0;
    tick(); tick();
    check("flush_full_single_out_valid", 32'(out_valid), 32'(0));
    check("flush_full_frame_cnt", 32'(frame_cnt), 32'(2));
    check("queue_drained", 32'(exp_q.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/radix4_demux_framer.md
RADIX4_DEMUX_FRAMER -- requirements
Module: radix4_demux_framer

Interface
REQ-001 SHALL have parameter WIDTH, default 1, meaning the width of one lane item.
REQ-002 SHALL have parameter CNTW, default 8, meaning the width of the emitted-frame counter.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  upstream item present.
REQ-006 SHALL have port in_ready  output  1  item accepted this cycle when in_valid and in_ready are both 1.
REQ-007 SHALL have port in_data  input  WIDTH  item to route to the current lane.
REQ-008 SHALL have port flush  input  1  request to emit a partially filled frame.
REQ-009 SHALL have port out_valid  output  1  frame held in the output register.
REQ-010 SHALL have port out_ready  input  1  downstream takes the frame when out_valid and out_ready are both 1.
REQ-011 SHALL have port out_word  output  4*WIDTH  lane k at bits [k*WIDTH +: WIDTH]; lane 0 is least significant.
REQ-012 SHALL have port out_mask  output  4  bit k is set when lane k holds written data.
REQ-013 SHALL have port out_sel  output  2  index of the last lane written in the emitted frame.
REQ-014 SHALL have port frame_cnt  output  CNTW  number of frames emitted, modulo 2^CNTW.

Function
REQ-015 SHALL act as the 1-to-4 counterpart of the 4-to-1 mux: serial items fill lanes 0,1,2,3 in order into an assembly buffer (acc, acc_mask, 2-bit lane counter cnt).
REQ-016 SHALL, on each accept, write in_data to lane cnt, set acc_mask[cnt], and advance cnt modulo 4.
REQ-017 SHALL define "output free" as (out_valid==0) or (out_ready==1).
REQ-018 SHALL transfer the frame on the accept that fills lane 3: out_word=acc including the new item, out_mask=4'b1111, out_sel=3, out_valid=1 on the next edge (latency 1 cycle from the 4th accept); cnt, acc and acc_mask clear.
REQ-019 SHALL drive in_ready = !(cnt==3 && out_valid && !out_ready), so a completing item is never accepted without room to transfer.
REQ-020 SHALL, when flush=1 and the output is free and the frame is nonempty (acc_mask!=0 or an accept occurs this cycle), transfer the partial frame, including any same-cycle accepted item; unwritten lanes read 0, out_sel = highest written lane.
REQ-021 SHALL ignore flush when the frame is empty or the output is not free; the requester holds flush until it takes effect.
REQ-022 SHALL treat flush coinciding with a lane-3 accept as a single full-frame transfer, not two frames.
REQ-023 SHALL clear out_valid after a take (out_valid && out_ready) unless a new transfer loads in the same cycle; back-to-back frames SHALL stream with no bubble.
REQ-024 SHALL hold out_word, out_mask and out_sel stable while out_valid=1 and out_ready=0.
REQ-025 SHALL increment frame_cnt by 1 on each take, wrapping from 2^CNTW-1 to 0.
REQ-026 SHALL accept items while a frame waits in the output register, as long as cnt<3.

Reset
REQ-027 SHALL, when rst=1 at a rising edge, set cnt=0, acc=0, acc_mask=0, out_valid=0, out_word=0, out_mask=0, out_sel=0, frame_cnt=0, and discard any partial or pending frame; rst SHALL take priority over accept, flush and take.
REQ-028 SHALL drive in_ready=1 in the first cycle after reset.

Verification
REQ-029 WIDTH=1; accept 1,1,0,0 on consecutive cycles with out_ready=1 -> the next cycle shows out_valid=1, out_word=4'b0011, out_mask=4'b1111, out_sel=3, and frame_cnt becomes 1 after the take.
REQ-030 Accept 1,0,1, then pulse flush with no item -> out_word=4'b0101, out_mask=4'b0111, out_sel=2; the next frame starts at lane 0.
REQ-031 out_ready=0 with a full frame held; send 3 more items -> all are accepted, and the 4th item sees in_ready=0 until out_ready=1; the held frame never changes.
REQ-032 Stream 8 items continuously with out_ready=1 -> two frames on consecutive take cycles with no bubble; frame_cnt=2.
REQ-033 Assert rst after 2 accepts while a frame is pending -> all outputs read 0 and in_ready=1; the next 4 items form a fresh frame.
REQ-034 Drive 4-item frames with CNTW=2 and out_ready=1 -> frame_cnt counts 1,2,3 then wraps to 0; assert flush with an empty frame -> no out_valid.
